crc_serial_engine: RTL and testbench

CRC_SERIAL_ENGINE -- requirements
Module: crc_serial_engine

---
 rtl/crc_pkg.sv | 15 +
 rtl/crc_lfsr_step.sv | 19 +
 rtl/crc_serial_engine.sv | 111 +++++++++++
 tb/tb_crc_serial_engine.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc_pkg.sv
// Shared definitions for the serial CRC engine: FSM encoding and stock polynomials.
package crc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Generator polynomials without the implicit top term.
  localparam logic [3:0]  CRC4  = 4'h3;
  localparam logic [7:0]  CRC8  = 8'h07;
  localparam logic [15:0] CRC16 = 16'h1021;

endpackage

// File: rtl/crc_lfsr_step.sv
// One-bit Galois LFSR update: feedback = msb ^ bit, shift left, xor in POLY on feedback.
module crc_lfsr_step #(
  parameter int unsigned      CRC_W = 4,
  parameter logic [CRC_W-1:0] POLY  = 4'h3
) (
  input  logic [CRC_W-1:0] crc_in,
  input  logic             bit_in,
  output logic [CRC_W-1:0] crc_out
);

  logic fb;

  // Single Galois step, purely combinational.
  always_comb begin
    fb      = crc_in[CRC_W-1] ^ bit_in;
    crc_out = {crc_in[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
  end

endmodule

// File: rtl/crc_serial_engine.sv
// Bit-serial CRC generator/checker: captures a word on start, shifts it MSB first
// through a Galois LFSR, then reports the CRC (and a mismatch flag in check mode).
module crc_serial_engine
  import crc_pkg::*;
#(
  parameter int unsigned      DATA_W = 8,
  parameter int unsigned      CRC_W  = 4,
  parameter logic [CRC_W-1:0] POLY   = CRC_W'(CRC4),
  parameter logic [CRC_W-1:0] INIT   = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [DATA_W-1:0] data_in,
  input  logic [CRC_W-1:0]  crc_in,
  output logic              busy,
  output logic              done,
  output logic              write_mem_en,
  output logic [CRC_W-1:0]  crc_out,
  output logic              error
);

  localparam int unsigned      CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [DATA_W-1:0]  data_q;
  logic               mode_q;
  logic [CRC_W-1:0]   crc_ref_q;
  logic [CRC_W-1:0]   crc_q;
  logic [CRC_W-1:0]   crc_next;
  logic [CRC_W-1:0]   crc_out_q;
  logic               error_q;
  logic               last_bit;

  assign last_bit = (cnt_q == CNT_LAST);

  crc_lfsr_step #(
    .CRC_W (CRC_W),
    .POLY  (POLY)
  ) u_step (
    .crc_in  (crc_q),
    .bit_in  (data_q[DATA_W-1]),
    .crc_out (crc_next)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: start only matters in IDLE, DONE always falls back to IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start)    state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture, bit counter, working CRC and result registers.
  // Result and mismatch flag are registered on SHIFT->DONE so both are valid with done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      data_q    <= '0;
      mode_q    <= 1'b0;
      crc_ref_q <= '0;
      crc_q     <= '0;
      crc_out_q <= '0;
      error_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (start) begin
            data_q    <= data_in;
            mode_q    <= mode;
            crc_ref_q <= crc_in;
            crc_q     <= INIT;
            error_q   <= 1'b0;
          end
        end
        SHIFT: begin
          crc_q  <= crc_next;
          data_q <= data_q << 1;
          if (last_bit) begin
            cnt_q     <= '0;
            crc_out_q <= crc_next;
            error_q   <= mode_q && (crc_next != crc_ref_q);
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: cnt_q <= '0;
      endcase
    end
  end

  assign busy         = (state_q == SHIFT);
  assign done         = (state_q == DONE);
  assign write_mem_en = done && !mode_q;
  assign crc_out      = crc_out_q;
  assign error        = error_q;

endmodule

// File: tb/tb_crc_serial_engine.sv
// Directed self-checking bench for crc_serial_engine (CRC4 default and a CRC16 instance).
module tb_crc_serial_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, mode;
  logic [7:0]  data_in;
  logic [3:0]  crc_in;
  logic        busy, done, wme;
  logic [3:0]  crc_out;
  logic        error;

  logic        start16, mode16;
  logic [15:0] data16, crc16_in;
  logic        busy16, done16, wme16;
  logic [15:0] crc16_out;
  logic        error16;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  crc_serial_engine u0 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .data_in(data_in), .crc_in(crc_in),
    .busy(busy), .done(done), .write_mem_en(wme), .crc_out(crc_out), .error(error)
  );

  crc_serial_engine #(
    .DATA_W(16), .CRC_W(16), .POLY(16'h1021), .INIT(16'hFFFF)
  ) u1 (
    .clk(clk), .rst(rst), .start(start16), .mode(mode16), .data_in(data16), .crc_in(crc16_in),
    .busy(busy16), .done(done16), .write_mem_en(wme16), .crc_out(crc16_out), .error(error16)
  );

  // Bitwise CRC-16 reference: MSB first, Galois form, poly 0x1021, preset 0xFFFF.
  function automatic logic [15:0] crc16_ref(input logic [15:0] d);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 15; i >= 0; i--) begin
      fb = c[15] ^ d[i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  // Launch one operation on u0 and observe 14 cycles; inputs are scrambled after acceptance.
  task automatic do_op(input logic m, input logic [7:0] d, input logic [3:0] c,
                       output int busy_cnt, output int done_cyc,
                       output int done_cnt, output int wme_cnt);
    @(negedge clk);
    mode = m; data_in = d; crc_in = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0; mode = ~m; data_in = ~d; crc_in = ~c;
    busy_cnt = 0; done_cyc = -1; done_cnt = 0; wme_cnt = 0;
    for (int k = 1; k <= 14; k++) begin
      if (k > 1) @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = k;
      end
      if (wme) wme_cnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; mode = 1'b0; data_in = '0; crc_in = '0;
    start16 = 1'b0; mode16 = 1'b0; data16 = '0; crc16_in = '0;
    @(negedge clk);
    checks++;
    if ({busy, done, wme, crc_out, error} !== 8'h00) begin
      failures++;
      $display("FAIL reset_outputs got=%0h exp=0", {busy, done, wme, crc_out, error});
    end
    checks++;
    if (u0.cnt_q !== 4'd0) begin
      failures++;
      $display("FAIL reset_counter got=%0d exp=0", u0.cnt_q);
    end
    checks++;
    if ({busy16, done16, wme16, crc16_out, error16} !== 20'h0) begin
      failures++;
      $display("FAIL reset_outputs16 got=%0h exp=0", {busy16, done16, wme16, crc16_out, error16});
    end
    rst = 1'b0;
  endtask

  task automatic test_generate();
    int bc, dc, dn, wc;
    do_op(1'b0, 8'hA5, 4'h0, bc, dc, dn, wc);
    checks++;
    if (bc !== 8) begin failures++; $display("FAIL gen_a5_busy_cycles got=%0d exp=8", bc); end
    checks++;
    if (dc !== 9) begin failures++; $display("FAIL gen_a5_done_cycle got=%0d exp=9", dc); end
    checks++;
    if (dn !== 1) begin failures++; $display("FAIL gen_a5_done_count got=%0d exp=1", dn); end
    checks++;
    if (wc !== 1) begin failures++; $display("FAIL gen_a5_wme_count got=%0d exp=1", wc); end
    checks++;
    if (crc_out !== 4'hB) begin failures++; $display("FAIL gen_a5_crc got=%0h exp=b", crc_out); end
    checks++;
    if (error !== 1'b0) begin failures++; $display("FAIL gen_a5_error got=%0b exp=0", error); end

    do_op(1'b0, 8'h01, 4'h0, bc, dc, dn, wc);
    checks++;
    if (crc_out !== 4'h3) begin failures++; $display("FAIL gen_01_crc got=%0h exp=3", crc_out); end

    do_op(1'b0, 8'h00, 4'h0, bc, dc, dn, wc);
    checks++;
    if (crc_out !== 4'h0) begin failures++; $display("FAIL gen_00_crc got=%0h exp=0", crc_out); end
  endtask

  task automatic test_check();
    int bc, dc, dn, wc;
    do_op(1'b1, 8'hA5, 4'hB, bc, dc, dn, wc);
    checks++;
    if (dn !== 1) begin failures++; $display("FAIL chk_ok_done_count got=%0d exp=1", dn); end
    checks++;
    if (wc !== 0) begin failures++; $display("FAIL chk_ok_wme_count got=%0d exp=0", wc); end
    checks++;
    if (error !== 1'b0) begin failures++; $display("FAIL chk_ok_error got=%0b exp=0", error); end

    do_op(1'b1, 8'hA5, 4'hA, bc, dc, dn, wc);
    checks++;
    if (error !== 1'b1) begin failures++; $display("FAIL chk_bad_error got=%0b exp=1", error); end
    checks++;
    if (crc_out !== 4'hB) begin failures++; $display("FAIL chk_bad_crc got=%0h exp=b", crc_out); end
    repeat (5) @(negedge clk);
    checks++;
    if (error !== 1'b1) begin failures++; $display("FAIL chk_bad_error_held got=%0b exp=1", error); end

    do_op(1'b0, 8'h01, 4'h0, bc, dc, dn, wc);
    checks++;
    if (error !== 1'b0) begin failures++; $display("FAIL chk_error_cleared got=%0b exp=0", error); end
  endtask

  task automatic test_ignore_start();
    int dn;
    dn = 0;
    @(negedge clk);
    mode = 1'b0; data_in = 8'hA5; start = 1'b1;
    @(negedge clk);
    start = 1'b0; data_in = 8'h00;
    for (int k = 1; k <= 25; k++) begin
      if (k > 1) @(negedge clk);
      if (done) dn++;
      if (k == 3) start = 1'b1;
      if (k == 4) start = 1'b0;
    end
    checks++;
    if (dn !== 1) begin failures++; $display("FAIL ignore_start_done_count got=%0d exp=1", dn); end
    checks++;
    if (crc_out !== 4'hB) begin failures++; $display("FAIL ignore_start_crc got=%0h exp=b", crc_out); end
  endtask

  task automatic test_back_to_back();
    int dcyc[4];
    int dn;
    dn = 0;
    @(negedge clk);
    mode = 1'b0; data_in = 8'hA5; start = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 32; k++) begin
      if (k > 1) @(negedge clk);
      if (done) begin
        if (dn < 4) dcyc[dn] = k;
        dn++;
      end
    end
    start = 1'b0;
    checks++;
    if (dn !== 3) begin
      failures++; $display("FAIL b2b_done_count got=%0d exp=3", dn);
    end else begin
      checks++;
      if (dcyc[0] !== 9) begin failures++; $display("FAIL b2b_first_done got=%0d exp=9", dcyc[0]); end
      checks++;
      if (dcyc[1] - dcyc[0] !== 10) begin
        failures++; $display("FAIL b2b_period1 got=%0d exp=10", dcyc[1] - dcyc[0]);
      end
      checks++;
      if (dcyc[2] - dcyc[1] !== 10) begin
        failures++; $display("FAIL b2b_period2 got=%0d exp=10", dcyc[2] - dcyc[1]);
      end
    end
    repeat (15) @(negedge clk);
    checks++;
    if (crc_out !== 4'hB) begin failures++; $display("FAIL b2b_crc got=%0h exp=b", crc_out); end
  endtask

  task automatic test_reset_mid_shift();
    int bc, dc, dn, wc, dd;
    dd = 0;
    @(negedge clk);
    mode = 1'b0; data_in = 8'hA5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL rst_mid_busy_before got=%0b exp=1", busy); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, wme, crc_out, error} !== 8'h00) begin
      failures++; $display("FAIL rst_mid_outputs got=%0h exp=0", {busy, done, wme, crc_out, error});
    end
    checks++;
    if (u0.cnt_q !== 4'd0) begin failures++; $display("FAIL rst_mid_counter got=%0d exp=0", u0.cnt_q); end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done || busy) dd++;
    end
    checks++;
    if (dd !== 0) begin failures++; $display("FAIL rst_mid_no_activity got=%0d exp=0", dd); end
    do_op(1'b0, 8'hA5, 4'h0, bc, dc, dn, wc);
    checks++;
    if (dc !== 9) begin failures++; $display("FAIL rst_mid_next_done got=%0d exp=9", dc); end
    checks++;
    if (crc_out !== 4'hB) begin failures++; $display("FAIL rst_mid_next_crc got=%0h exp=b", crc_out); end
  endtask

  task automatic test_wide();
    logic [15:0] exp;
    int dc, wc;
    exp = crc16_ref(16'h3132);
    dc = -1; wc = 0;
    @(negedge clk);
    mode16 = 1'b0; data16 = 16'h3132; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0; data16 = 16'h0000;
    for (int k = 1; k <= 22; k++) begin
      if (k > 1) @(negedge clk);
      if (done16 && dc < 0) dc = k;
      if (wme16) wc++;
    end
    checks++;
    if (dc !== 17) begin failures++; $display("FAIL wide_done_cycle got=%0d exp=17", dc); end
    checks++;
    if (wc !== 1) begin failures++; $display("FAIL wide_wme_count got=%0d exp=1", wc); end
    checks++;
    if (crc16_out !== exp) begin failures++; $display("FAIL wide_crc got=%0h exp=%0h", crc16_out, exp); end

    @(negedge clk);
    mode16 = 1'b1; data16 = 16'h3132; crc16_in = exp; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (error16 !== 1'b0) begin failures++; $display("FAIL wide_check_error got=%0b exp=0", error16); end
  endtask

  initial begin
    test_reset();
    test_generate();
    test_check();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_shift();
    test_wide();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
